// File: rtl/vball_pkg.sv
// Shared constants, enums and the round-robin pick for the vball ROM arbiter.
package vball_pkg;
    localparam int AW     = 25;
    localparam int BG_AW  = 19;
    localparam int PCM_AW = 18;

    localparam logic [AW-1:0] BG_BASE  = 25'h0200000;
    localparam logic [AW-1:0] PCM_BASE = 25'h0300000;

    typedef enum logic {CL_BG = 1'b0, CL_PCM = 1'b1} client_e;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_e;

    // With both clients pending, the one not granted last time wins.
    function automatic client_e pick_client(input client_e last, input logic bg_p, input logic pcm_p);
        client_e w;
        w = CL_BG;
        if (bg_p && pcm_p) begin
            w = (last == CL_BG) ? CL_PCM : CL_BG;
        end else if (pcm_p) begin
            w = CL_PCM;
        end
        return w;
    endfunction
endpackage

// File: rtl/vball_rom_arbiter_if.sv
// Byte-wide external memory read port shared by the arbiter and the memory controller.
interface vball_rom_arbiter_if #(parameter int AW = 25);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [7:0]    mem_dout;

    modport master (output mem_addr, output mem_rd, input mem_ack, input mem_dout);
    modport slave  (input mem_addr, input mem_rd, output mem_ack, output mem_dout);
endinterface

// File: rtl/vball_rom_client.sv
// Per-client request tracking: pending flag, one-entry tagged data cache and ready compare.
module vball_rom_client #(
    parameter int CW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read_i,
    input  logic [CW-1:0] addr_i,
    input  logic          clr_pend_i,
    input  logic          fill_i,
    input  logic [CW-1:0] fill_tag_i,
    input  logic [7:0]    fill_data_i,
    output logic          pend_o,
    output logic [7:0]    data_o,
    output logic          rdy_o
);
    logic          pend_q, pend_d;
    logic          val_q;
    logic [CW-1:0] tag_q;
    logic [7:0]    data_q;
    logic          rdy_q;
    logic          hit;

    // A strobe landing on the fill cycle counts as a miss so it can never be swallowed.
    assign hit = val_q && (tag_q == addr_i) && !fill_i;

    always_comb begin
        pend_d = pend_q;
        if (clr_pend_i) pend_d = 1'b0;
        if (read_i && !hit) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            val_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            rdy_q  <= val_q && (tag_q == addr_i);
            if (fill_i) begin
                val_q  <= 1'b1;
                tag_q  <= fill_tag_i;
                data_q <= fill_data_i;
            end
        end
    end

    assign pend_o = pend_q;
    assign data_o = data_q;
    assign rdy_o  = rdy_q;
endmodule

// File: rtl/vball_rom_arbiter.sv
// Round-robin arbiter multiplexing the bg gfx and OKI PCM ROM fetches onto one external read port.
module vball_rom_arbiter #(
    parameter int            AW       = vball_pkg::AW,
    parameter logic [AW-1:0] BG_BASE  = AW'(vball_pkg::BG_BASE),
    parameter logic [AW-1:0] PCM_BASE = AW'(vball_pkg::PCM_BASE)
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                bg_read,
    input  logic [18:0]         bg_addr,
    output logic [7:0]          bg_data,
    output logic                bg_rdy,
    input  logic                pcm_read,
    input  logic [17:0]         pcm_addr,
    output logic [7:0]          pcm_data,
    output logic                pcm_rdy,
    vball_rom_arbiter_if.master mem
);
    import vball_pkg::*;

    state_e           state_q, state_d;
    client_e          gnt_q, last_q, winner;
    logic [BG_AW-1:0] req_addr_q;
    logic [AW-1:0]    mem_addr_q;
    logic             mem_rd_q;
    logic             bg_pend, pcm_pend;
    logic             latch, issue, fill;
    logic [AW-1:0]    base_sel;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bg_pend || pcm_pend) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mem.mem_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        latch    = (state_q == ST_IDLE) && (bg_pend || pcm_pend);
        issue    = (state_q == ST_ISSUE);
        fill     = (state_q == ST_WAIT) && mem.mem_ack;
        winner   = pick_client(last_q, bg_pend, pcm_pend);
        base_sel = (gnt_q == CL_BG) ? BG_BASE : PCM_BASE;
    end

    // Address sum wraps modulo 2^AW; no range checking.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            gnt_q      <= CL_BG;
            last_q     <= CL_PCM;
            req_addr_q <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
        end else begin
            if (latch) begin
                gnt_q      <= winner;
                last_q     <= winner;
                req_addr_q <= (winner == CL_BG) ? bg_addr : {1'b0, pcm_addr};
            end
            if (issue) begin
                mem_addr_q <= base_sel + AW'(req_addr_q);
                mem_rd_q   <= 1'b1;
            end
            if (fill) mem_rd_q <= 1'b0;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_rd   = mem_rd_q;

    vball_rom_client #(.CW(BG_AW)) u_bg (
        .clk         (clk_sys),
        .rst         (reset),
        .read_i      (bg_read),
        .addr_i      (bg_addr),
        .clr_pend_i  (issue && (gnt_q == CL_BG)),
        .fill_i      (fill && (gnt_q == CL_BG)),
        .fill_tag_i  (req_addr_q),
        .fill_data_i (mem.mem_dout),
        .pend_o      (bg_pend),
        .data_o      (bg_data),
        .rdy_o       (bg_rdy)
    );

    vball_rom_client #(.CW(PCM_AW)) u_pcm (
        .clk         (clk_sys),
        .rst         (reset),
        .read_i      (pcm_read),
        .addr_i      (pcm_addr),
        .clr_pend_i  (issue && (gnt_q == CL_PCM)),
        .fill_i      (fill && (gnt_q == CL_PCM)),
        .fill_tag_i  (req_addr_q[PCM_AW-1:0]),
        .fill_data_i (mem.mem_dout),
        .pend_o      (pcm_pend),
        .data_o      (pcm_data),
        .rdy_o       (pcm_rdy)
    );
endmodule

// File: tb/tb_vball_rom_arbiter.sv
// Self-checking bench for vball_rom_arbiter: directed scenarios plus a randomized run against a data-integrity model.
module tb_vball_rom_arbiter;
    localparam logic [24:0] BGB  = 25'h0200000;
    localparam logic [24:0] PCMB = 25'h0300000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bg_read = 1'b0, pcm_read = 1'b0;
    logic [18:0] bg_addr = '0;
    logic [17:0] pcm_addr = '0;
    logic [7:0]  bg_data, pcm_data, bg_data2, pcm_data2;
    logic        bg_rdy, pcm_rdy, bg_rdy2, pcm_rdy2;

    logic        dir_ack = 1'b0, auto_ack = 1'b0, auto_mode = 1'b0;
    logic [7:0]  dir_dout = '0, auto_dout = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vball_rom_arbiter_if #(.AW(25)) m1 ();
    vball_rom_arbiter_if #(.AW(25)) m2 ();

    assign m1.mem_ack  = dir_ack | auto_ack;
    assign m1.mem_dout = auto_mode ? auto_dout : dir_dout;
    assign m2.mem_ack  = 1'b0;
    assign m2.mem_dout = 8'h00;

    vball_rom_arbiter dut (
        .clk_sys(clk), .reset(reset),
        .bg_read(bg_read), .bg_addr(bg_addr), .bg_data(bg_data), .bg_rdy(bg_rdy),
        .pcm_read(pcm_read), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_rdy(pcm_rdy),
        .mem(m1.master)
    );

    vball_rom_arbiter #(.PCM_BASE(25'h1FFFFFF)) dut_wrap (
        .clk_sys(clk), .reset(reset),
        .bg_read(bg_read), .bg_addr(bg_addr), .bg_data(bg_data2), .bg_rdy(bg_rdy2),
        .pcm_read(pcm_read), .pcm_addr(pcm_addr), .pcm_data(pcm_data2), .pcm_rdy(pcm_rdy2),
        .mem(m2.master)
    );

    // Contents of external memory used by the randomized run.
    function automatic logic [7:0] mem_fn(input logic [24:0] a);
        return a[7:0] ^ {a[14:8], 1'b0} ^ a[22:15] ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_rd(input int maxc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < maxc && !ok) begin
            tick();
            cyc++;
            if (m1.mem_rd) ok = 1'b1;
        end
    endtask

    task automatic ack_dir(input logic [7:0] d);
        dir_dout = d;
        dir_ack  = 1'b1;
        tick();
        dir_ack  = 1'b0;
    endtask

    // Automatic memory responder with random latency; also checks every address lands in a client region.
    initial begin : responder
        int lat;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) begin
                auto_ack = 1'b0;
            end else if (auto_mode && m1.mem_rd) begin
                if (lat == 0) begin
                    checks++;
                    if (!(((m1.mem_addr - BGB) < 25'h80000) || ((m1.mem_addr - PCMB) < 25'h40000))) begin
                        errors++;
                        $display("FAIL rand_region: mem_addr=%h outside bg/pcm regions", m1.mem_addr);
                    end
                    auto_dout = mem_fn(m1.mem_addr);
                    auto_ack  = 1'b1;
                    lat = $urandom_range(3, 0);
                end else begin
                    lat--;
                end
            end
        end
    end

    task automatic test_reset();
        tick();
        checks++;
        if (m1.mem_rd !== 1'b0 || m1.mem_addr !== 25'h0) begin
            errors++; $display("FAIL reset_mem: rd=%b addr=%h want 0/0", m1.mem_rd, m1.mem_addr);
        end
        checks++;
        if (bg_data !== 8'h00 || pcm_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: bg=%h pcm=%h want 00/00", bg_data, pcm_data);
        end
        checks++;
        if (bg_rdy !== 1'b0 || pcm_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: bg=%b pcm=%b want 0/0", bg_rdy, pcm_rdy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_bg_fetch();
        int cyc; bit ok;
        bg_addr = 19'h00010; bg_read = 1'b1;
        tick();
        bg_read = 1'b0;
        wait_rd(10, cyc, ok);
        checks++;
        if (!ok || cyc != 2) begin
            errors++; $display("FAIL bg_latency: ok=%b cycles=%0d want 2", ok, cyc);
        end
        checks++;
        if (m1.mem_addr !== 25'h0200010) begin
            errors++; $display("FAIL bg_addr: got %h want 0200010", m1.mem_addr);
        end
        tick(); tick();
        ack_dir(8'hA5);
        checks++;
        if (m1.mem_rd !== 1'b0 || bg_data !== 8'hA5 || bg_rdy !== 1'b0) begin
            errors++; $display("FAIL bg_ack: rd=%b data=%h rdy=%b want 0/a5/0", m1.mem_rd, bg_data, bg_rdy);
        end
        tick();
        checks++;
        if (bg_rdy !== 1'b1) begin
            errors++; $display("FAIL bg_rdy: got %b want 1", bg_rdy);
        end
    endtask

    task automatic test_hit();
        bit bad;
        bad = 1'b0;
        bg_read = 1'b1;
        tick();
        bg_read = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m1.mem_rd !== 1'b0 || bg_rdy !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL hit: rd=%b rdy=%b want no fetch and rdy=1", m1.mem_rd, bg_rdy);
        end
    endtask

    task automatic test_round_robin();
        int cyc; bit ok;
        do_reset();
        bg_addr = 19'h00001; pcm_addr = 18'h3FFFF;
        bg_read = 1'b1; pcm_read = 1'b1;
        tick();
        bg_read = 1'b0; pcm_read = 1'b0;
        wait_rd(10, cyc, ok);
        checks++;
        if (!ok || m1.mem_addr !== 25'h0200001) begin
            errors++; $display("FAIL rr_first: ok=%b addr=%h want 0200001", ok, m1.mem_addr);
        end
        bg_addr = 19'h00022; bg_read = 1'b1;
        tick();
        bg_read = 1'b0;
        ack_dir(8'h31);
        tick();
        checks++;
        if (bg_data !== 8'h31 || bg_rdy !== 1'b0) begin
            errors++; $display("FAIL rr_stale: data=%h rdy=%b want 31/0", bg_data, bg_rdy);
        end
        wait_rd(10, cyc, ok);
        checks++;
        if (!ok || m1.mem_addr !== 25'h033FFFF) begin
            errors++; $display("FAIL rr_pcm: ok=%b addr=%h want 033ffff", ok, m1.mem_addr);
        end
        bg_addr = 19'h00033; bg_read = 1'b1;
        tick();
        bg_read = 1'b0;
        ack_dir(8'h32);
        wait_rd(10, cyc, ok);
        checks++;
        if (!ok || m1.mem_addr !== 25'h0200033) begin
            errors++; $display("FAIL rr_third: ok=%b addr=%h want 0200033", ok, m1.mem_addr);
        end
        ack_dir(8'h33);
        tick(); tick();
        checks++;
        if (bg_rdy !== 1'b1 || bg_data !== 8'h33 || pcm_rdy !== 1'b1 || pcm_data !== 8'h32) begin
            errors++; $display("FAIL rr_final: bg %b/%h pcm %b/%h want 1/33 1/32", bg_rdy, bg_data, pcm_rdy, pcm_data);
        end
    endtask

    task automatic test_moved();
        int cyc; bit ok;
        pcm_addr = 18'h00100; pcm_read = 1'b1;
        tick();
        pcm_read = 1'b0;
        wait_rd(10, cyc, ok);
        checks++;
        if (!ok || m1.mem_addr !== 25'h0300100) begin
            errors++; $display("FAIL mv_first: ok=%b addr=%h want 0300100", ok, m1.mem_addr);
        end
        pcm_addr = 18'h00101; pcm_read = 1'b1;
        tick();
        pcm_read = 1'b0;
        ack_dir(8'h11);
        tick(); tick();
        checks++;
        if (pcm_rdy !== 1'b0 || pcm_data !== 8'h11) begin
            errors++; $display("FAIL mv_stale: rdy=%b data=%h want 0/11", pcm_rdy, pcm_data);
        end
        wait_rd(10, cyc, ok);
        checks++;
        if (!ok || m1.mem_addr !== 25'h0300101) begin
            errors++; $display("FAIL mv_refetch: ok=%b addr=%h want 0300101", ok, m1.mem_addr);
        end
        ack_dir(8'h22);
        tick(); tick();
        checks++;
        if (pcm_rdy !== 1'b1 || pcm_data !== 8'h22) begin
            errors++; $display("FAIL mv_final: rdy=%b data=%h want 1/22", pcm_rdy, pcm_data);
        end
    endtask

    task automatic test_reset_in_wait();
        int cyc; bit ok;
        bit bad;
        bg_addr = 19'h00044; bg_read = 1'b1;
        tick();
        bg_read = 1'b0;
        wait_rd(10, cyc, ok);
        reset = 1'b1;
        #1;
        checks++;
        if (!ok || m1.mem_rd !== 1'b0) begin
            errors++; $display("FAIL rst_async: ok=%b rd=%b want rd=0 during reset", ok, m1.mem_rd);
        end
        tick();
        reset = 1'b0;
        tick();
        ack_dir(8'h77);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m1.mem_rd !== 1'b0 || bg_rdy !== 1'b0 || bg_data !== 8'h00 || pcm_rdy !== 1'b0 || pcm_data !== 8'h00)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL rst_stale_ack: rd=%b bg %b/%h pcm %b/%h want all 0",
                               m1.mem_rd, bg_rdy, bg_data, pcm_rdy, pcm_data);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        pcm_addr = 18'h00002; pcm_read = 1'b1;
        tick();
        pcm_read = 1'b0;
        cyc = 0;
        while (cyc < 10 && !m2.mem_rd) begin
            tick();
            cyc++;
        end
        checks++;
        if (m2.mem_rd !== 1'b1 || m2.mem_addr !== 25'h0000001) begin
            errors++; $display("FAIL wrap: rd=%b addr=%h want 1/0000001", m2.mem_rd, m2.mem_addr);
        end
    endtask

    task automatic test_random();
        logic [7:0] bg_prev, pcm_prev;
        do_reset();
        auto_mode = 1'b1;
        bg_prev = bg_data;
        pcm_prev = pcm_data;
        for (int n = 0; n < 600; n++) begin
            tick();
            // rdy reflects the cache as it stood one cycle earlier, hence the previous data sample.
            if (bg_rdy) begin
                checks++;
                if (bg_prev !== mem_fn(BGB + {6'd0, bg_addr})) begin
                    errors++; $display("FAIL rand_bg: data=%h want %h addr=%h", bg_prev, mem_fn(BGB + {6'd0, bg_addr}), bg_addr);
                end
            end
            if (pcm_rdy) begin
                checks++;
                if (pcm_prev !== mem_fn(PCMB + {7'd0, pcm_addr})) begin
                    errors++; $display("FAIL rand_pcm: data=%h want %h addr=%h", pcm_prev, mem_fn(PCMB + {7'd0, pcm_addr}), pcm_addr);
                end
            end
            bg_prev  = bg_data;
            pcm_prev = pcm_data;
            bg_read  = 1'b0;
            pcm_read = 1'b0;
            if ($urandom_range(3, 0) == 0) begin
                bg_addr = 19'h40000 + 19'($urandom_range(5, 0) * 16);
                bg_read = 1'b1;
            end
            if ($urandom_range(3, 0) == 0) begin
                pcm_addr = 18'h3FFF0 + 18'($urandom_range(5, 0));
                pcm_read = 1'b1;
            end
        end
        bg_read = 1'b1; pcm_read = 1'b1;
        tick();
        bg_read = 1'b0; pcm_read = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (bg_rdy !== 1'b1 || bg_data !== mem_fn(BGB + {6'd0, bg_addr})) begin
            errors++; $display("FAIL rand_settle_bg: rdy=%b data=%h want 1/%h", bg_rdy, bg_data, mem_fn(BGB + {6'd0, bg_addr}));
        end
        checks++;
        if (pcm_rdy !== 1'b1 || pcm_data !== mem_fn(PCMB + {7'd0, pcm_addr})) begin
            errors++; $display("FAIL rand_settle_pcm: rdy=%b data=%h want 1/%h", pcm_rdy, pcm_data, mem_fn(PCMB + {7'd0, pcm_addr}));
        end
        auto_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bg_fetch();
        test_hit();
        test_round_robin();
        test_moved();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vball_rom_arbiter.md
Name: vball_rom_arbiter

Overview:
- Sits directly downstream of the vball core's two external ROM ports.
  - Background graphics fetch: bg_read / bg_addr → bg_data.
  - OKI PCM fetch: pcm_rom_read / pcm_rom_addr → pcm_rom_data, pcm_rom_data_rdy.
- Multiplexes both onto the single byte-wide DDR/SDRAM read port of the MiSTer framework.
- Provides per-client address tagging, a one-entry hit cache per client, and a rom_ok-style ready for the PCM client.

Parameters:
- BG_BASE, 25'h0200000, byte offset of background gfx region in external memory
- PCM_BASE, 25'h0300000, byte offset of PCM sample region in external memory
- AW, 25, external memory address width

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- bg_read  in  1  request strobe, one-cycle pulse from bg fetcher
- bg_addr  in  19  bg byte address, stable from strobe until bg_rdy
- bg_data  out  8  last fetched bg byte
- bg_rdy  out  1  high while bg_data belongs to current bg_addr
- pcm_read  in  1  request strobe (pulse on pcm address change)
- pcm_addr  in  18  PCM byte address
- pcm_data  out  8  last fetched PCM byte
- pcm_rdy  out  1  high while pcm_data belongs to current pcm_addr (drives jt6295 rom_ok)
- mem_addr  out  AW  external read address
- mem_rd  out  1  read request level, held until mem_ack
- mem_ack  in  1  one-cycle pulse, mem_dout valid same cycle
- mem_dout  in  8  external read data

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - mem_rd=0, mem_addr=0.
  - bg_data=0, pcm_data=0.
  - bg_rdy=0, pcm_rdy=0.
  - Both pending flags and both valid flags are cleared.
- Per client c (bg, pcm), registered state: pend_c, tag_c (address of data_c), val_c.
  - Ready: rdy_c = val_c && (tag_c == addr_c), registered, 1-cycle lag.
  - Strobe handling, on read_c:
    - If val_c && addr_c == tag_c: hit, no fetch, pend_c unchanged.
    - Otherwise pend_c <= 1.
  - Strobes while pend_c=1 coalesce: the latest addr_c is sampled at grant time.
- FSM, three states:
  - IDLE:
    - If any pend set, go to ISSUE.
    - Select client by round-robin: last_grant toggles on each grant.
    - If both pending, the client not granted last wins.
    - If only one is pending, it wins regardless.
    - Latch gnt and req_addr = addr_gnt.
  - ISSUE:
    - mem_addr <= BASE_gnt + zero-extended req_addr.
    - mem_rd <= 1.
    - Clear pend_gnt.
    - Go to WAIT.
  - WAIT:
    - Hold mem_rd and mem_addr.
    - On mem_ack: mem_rd <= 0, data_gnt <= mem_dout, tag_gnt <= req_addr, val_gnt <= 1, go to IDLE.
- Latency:
  - Strobe to mem_rd rise: 2 cycles when idle.
  - mem_ack to rdy high: 2 cycles (data register, then rdy compare).
- Address moved during flight:
  - If addr_gnt changes while in WAIT, the data is still stored with the old tag.
  - rdy stays low; the new strobe has set pend, which causes a refetch.
- A strobe for the in-flight client in the same cycle as mem_ack sets pend again; it is never lost.
- A strobe for the other client in any state sets its pend; it is served at the next IDLE.
- mem_ack while in IDLE or ISSUE (e.g. a stale ack after reset) is ignored.
- Starvation bound: a pending client waits at most one foreign transaction.
- Address arithmetic:
  - Sum is AW bits; wrap-around modulo 2^AW.
  - No range checking.
- Outputs data_c and tag_c are never cleared except by reset.

Decomposition:
- Shared package vball_pkg:
  - AW
  - BG_BASE, PCM_BASE defaults
  - client-select enum {CL_BG, CL_PCM}
  - FSM state enum {ST_IDLE, ST_ISSUE, ST_WAIT}
- One natural sub-module: vball_rom_client.
  - Instantiated twice, parameterised by address width.
  - Contains pend/tag/val/data registers, hit compare and rdy generation.
  - The top holds the FSM, round-robin and mem port.

Test Plan:
- Reset released, bg_read with bg_addr=19'h00010, mem_ack 3 cycles after mem_rd → mem_addr=25'h0200010; bg_data=mem_dout=8'hA5; bg_rdy high 2 cycles after ack.
- Repeat bg_read at 19'h00010 after completion → no mem_rd; bg_rdy stays 1.
- bg_read and pcm_read in the same cycle (bg 19'h1, pcm 18'h3FFFF), then sustained bg strobes to new addresses → grants alternate bg, pcm (mem_addr 25'h033FFFF), bg; PCM waits ≤1 transaction.
- pcm_addr changes 18'h100→18'h101 with strobe during WAIT → first ack stored with tag 18'h100, pcm_rdy stays 0; second fetch at 25'h0300101 follows; pcm_rdy=1 afterwards.
- Assert reset in WAIT with mem_rd=1, then send mem_ack after release → mem_rd=0 immediately; ack ignored; val=0, rdy=0, data=0.
- PCM_BASE=25'h1FFFFFF, pcm_addr=18'h2 → mem_addr wraps to 25'h0000001.
